// File: rtl/max_exp_scheduler.sv
// Sequential max-exponent finder for the dot-product alignment stage.
// A single signed-max comparator is time-shared over N-1 cycles per vector;
// the result (max exponent, lowest index holding it) feeds the alignment shifters.

// Signed maximum of two exponents; a_gt_o flags that exp_a strictly won.
module max_exp_comparator #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH:0] exp_a_i,
  input  logic signed [WIDTH:0] exp_b_i,
  output logic signed [WIDTH:0] exp_o,
  output logic                  a_gt_o
);

  assign a_gt_o = (exp_a_i > exp_b_i);
  assign exp_o  = a_gt_o ? exp_a_i : exp_b_i;

endmodule

// state | meaning
// IDLE  | waiting for a vector, in_ready_o=1
// SCAN  | one comparison per cycle against elem[cnt]
// DONE  | result presented, retire and optionally accept next vector
module max_exp_scheduler #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [N*(WIDTH+1)-1:0]            exp_vec_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic signed [WIDTH:0]             max_exp_o,
  output logic [$clog2(N)-1:0]              max_idx_o,
  output logic                              busy_o
);

  localparam int EW    = WIDTH + 1;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [N*EW-1:0]         vec_q, vec_d;
  logic signed [EW-1:0]    max_q, max_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic signed [EW-1:0]    res_exp_q, res_exp_d;
  logic [IDX_W-1:0]        res_idx_q, res_idx_d;

  logic signed [EW-1:0]    elem [N];
  logic signed [EW-1:0]    cur_elem;
  logic signed [EW-1:0]    cmp_exp;
  logic                    cmp_a_gt;

  // Unpack the captured vector into addressable elements.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      elem[k] = vec_q[k*EW +: EW];
    end
  end

  assign cur_elem = elem[cnt_q];

  max_exp_comparator #(.WIDTH(WIDTH)) u_cmp (
    .exp_a_i (cur_elem),
    .exp_b_i (max_q),
    .exp_o   (cmp_exp),
    .a_gt_o  (cmp_a_gt)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    max_d       = max_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    res_exp_d   = res_exp_q;
    res_idx_d   = res_idx_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          vec_d   = exp_vec_i;
          max_d   = exp_vec_i[EW-1:0];
          idx_d   = '0;
          cnt_d   = IDX_W'(1);
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        busy_o = 1'b1;
        max_d  = cmp_exp;
        // Ties keep the older (lower) index.
        if (cmp_a_gt) begin
          idx_d = cnt_q;
        end
        if (cnt_q == IDX_W'(N-1)) begin
          res_exp_d = cmp_exp;
          res_idx_d = cmp_a_gt ? cnt_q : idx_q;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) begin
          if (in_valid_i) begin
            vec_d   = exp_vec_i;
            max_d   = exp_vec_i[EW-1:0];
            idx_d   = '0;
            cnt_d   = IDX_W'(1);
            state_d = S_SCAN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any scan or pending result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      res_exp_q <= '0;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      res_exp_q <= res_exp_d;
      res_idx_q <= res_idx_d;
    end
  end

  assign max_exp_o = res_exp_q;
  assign max_idx_o = res_idx_q;

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=>
      (out_valid_o && $stable(max_exp_o) && $stable(max_idx_o)));

  a_no_ready_in_scan: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == S_SCAN) |-> !in_ready_o);

  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(cnt_q) < N);

  a_in_valid_known: assert property (@(posedge clk_i) disable iff (rst_i)
    in_ready_o |-> !$isunknown(in_valid_i));

endmodule

// File: tb/tb_max_exp_scheduler.sv
// Directed bench for max_exp_scheduler (WIDTH=8, N=4) with a scoreboard monitor.
module tb_max_exp_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [35:0] exp_vec = '0;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [8:0]  max_exp_o;
  logic [1:0]  max_idx_o;
  logic        busy_o;

  max_exp_scheduler #(.WIDTH(8), .N(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .exp_vec_i   (exp_vec),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .max_exp_o   (max_exp_o),
    .max_idx_o   (max_idx_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {int mx; int ix;} res_t;
  res_t sbq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    return {d[8:0], c[8:0], b[8:0], a[8:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int mx, input int ix);
    res_t r;
    r.mx = mx;
    r.ix = ix;
    sbq.push_back(r);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(in_ready_o && !busy_o && sbq.size() == 0) && n < 100) begin
      tick();
      n++;
    end
    chk(nm, int'(n < 100), 1);
  endtask

  task automatic send(input int a, input int b, input int c, input int d,
                      input int mx, input int ix);
    int n = 0;
    exp_vec  = pack4(a, b, c, d);
    in_valid = 1'b1;
    while (!in_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk("send_ready_timeout", int'(n < 100), 1);
    push(mx, ix);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every retired result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_result actual=%0d/%0d required=none",
                 $signed(max_exp_o), max_idx_o);
      end else begin
        res_t r;
        r = sbq.pop_front();
        chk("sb_max_exp", int'($signed(max_exp_o)), r.mx);
        chk("sb_max_idx", int'(max_idx_o), r.ix);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t1;
    int t2;

    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready_o), 1);
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_max_exp", int'(max_exp_o), 0);
    chk("rst_max_idx", int'(max_idx_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rst = 1'b0;
    tick();

    // T1: latency and in_ready during SCAN
    exp_vec  = pack4(3, -5, 7, 2);
    in_valid = 1'b1;
    push(7, 2);
    tick();
    in_valid = 1'b0;
    chk("t1_ready_scan1", int'(in_ready_o), 0);
    chk("t1_busy_scan1", int'(busy_o), 1);
    tick();
    chk("t1_ready_scan2", int'(in_ready_o), 0);
    tick();
    chk("t1_ready_scan3", int'(in_ready_o), 0);
    chk("t1_valid_early", int'(out_valid_o), 0);
    tick();
    chk("t1_valid_at_t3", int'(out_valid_o), 1);
    wait_idle("t1_idle");

    // T2 / T3: extremes and ties
    send(-1, -256, -3, -200, -1, 0);
    send(-256, -256, -256, -256, -256, 0);
    send(-256, -256, -256, 255, 255, 3);
    send(5, 9, 9, 1, 9, 1);
    send(4, 4, 4, 4, 4, 0);
    wait_idle("t3_idle");

    // T4: backpressure
    out_ready = 1'b0;
    send(10, -2, 3, 10, 10, 0);
    n = 0;
    while (!out_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("t4_valid_timeout", int'(n < 20), 1);
    exp_vec  = pack4(100, 101, 102, 103);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", int'(out_valid_o), 1);
      chk("t4_hold_exp", int'($signed(max_exp_o)), 10);
      chk("t4_hold_idx", int'(max_idx_o), 0);
      chk("t4_hold_ready", int'(in_ready_o), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4_idle_ready", int'(in_ready_o), 1);
    chk("t4_idle_busy", int'(busy_o), 0);
    chk("t4_idle_valid", int'(out_valid_o), 0);
    chk("t4_idle_hold_exp", int'($signed(max_exp_o)), 10);
    repeat (6) tick();
    chk("t4_no_queued", int'(busy_o), 0);

    // T5: back-to-back
    wait_idle("t5_start");
    exp_vec  = pack4(1, 2, 3, 4);
    in_valid = 1'b1;
    push(4, 3);
    tick();
    exp_vec = pack4(8, 0, 0, 0);
    push(8, 0);
    n = 0;
    while (!out_valid_o && n < 20) begin
      tick();
      n++;
    end
    t1 = cyc;
    tick();
    in_valid = 1'b0;
    chk("t5_rescan", int'(out_valid_o), 0);
    n = 0;
    while (!out_valid_o && n < 20) begin
      tick();
      n++;
    end
    t2 = cyc;
    chk("t5_spacing", t2 - t1, 4);
    wait_idle("t5_idle");

    // T6: reset at the second SCAN edge
    exp_vec  = pack4(50, 60, 70, 80);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", int'(out_valid_o), 0);
    chk("t6_max_exp", int'(max_exp_o), 0);
    chk("t6_max_idx", int'(max_idx_o), 0);
    chk("t6_ready", int'(in_ready_o), 1);
    chk("t6_busy", int'(busy_o), 0);
    repeat (8) tick();
    chk("t6_no_stale", int'(out_valid_o), 0);
    send(-7, -3, -9, -3, -3, 1);
    wait_idle("t6_after");

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
